// File: rtl/div_unit.sv
// Iterative 32-bit MIPS divider (DIV/DIVU): radix-2 restoring, 32 iterations,
// quotient on lo, remainder on hi, pipeline stall while busy.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        stall,
    output logic        valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        neg_q, neg_r;
    logic [31:0] abs_a, abs_b;
    logic [33:0] trial;
    logic        accept;

    assign accept = (state == IDLE) && start && !cancel;
    assign abs_a  = (signed_div && a[31]) ? -a : a;
    assign abs_b  = (signed_div && b[31]) ? -b : b;

    // rem stays below the divisor, so the shifted value never sets bit 33
    // and trial[33] is a true borrow/sign flag.
    assign trial = {rem, quo[31]} - {2'b00, dvsr};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY: begin
                if (cancel)              state_nx = IDLE;
                else if (cnt == 5'd31)   state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= abs_a;
            dvsr  <= abs_b;
            neg_q <= signed_div & (a[31] ^ b[31]);
            neg_r <= signed_div & a[31];
        end else if (state == BUSY && !cancel) begin
            cnt <= cnt + 5'd1;
            if (!trial[33]) begin
                rem <= trial[32:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= {rem[31:0], quo[31]};
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign stall = accept || (state == BUSY);
    assign valid = (state == DONE);
    assign lo    = neg_q ? -quo : quo;
    assign hi    = neg_r ? -rem[31:0] : rem[31:0];

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, corner sequences
// (cancel, async reset, cancel priority) and random operands vs. a reference model.
module tb_div_unit;

    logic        clk, resetn, start, signed_div, cancel;
    logic [31:0] a, b;
    logic        stall, valid;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall      (stall),
        .valid      (valid),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Division by magnitudes, then the MIPS sign rules: quotient negative when
    // operand signs differ, remainder follows the dividend; x/0 gives all-ones.
    function automatic void model(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r);
        longint unsigned ua, ub;
        ua = (sd && av[31]) ? longint'(32'(-av)) : longint'(av);
        ub = (sd && bv[31]) ? longint'(32'(-bv)) : longint'(bv);
        if (ub == 0) begin
            q = 32'hFFFF_FFFF;
            r = 32'(ua);
        end else begin
            q = 32'(ua / ub);
            r = 32'(ua % ub);
        end
        if (sd && (av[31] ^ bv[31])) q = -q;
        if (sd && av[31])            r = -r;
    endfunction

    task automatic run_div(input string name, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] elo, input logic [31:0] ehi);
        int n, stall_cnt;
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = av; b = bv;
        #1;
        chk({name, "_stall_on_start"}, 32'(stall), 32'd1);
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
        n = 1;
        while (!valid && n < 40) begin
            if (stall) stall_cnt++;
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"},   32'(n), 32'd33);
        chk({name, "_stall_len"}, 32'(stall_cnt), 32'd33);
        chk({name, "_stall_done"}, 32'(stall), 32'd0);
        chk({name, "_lo"}, lo, elo);
        chk({name, "_hi"}, hi, ehi);
        @(posedge clk); #1;
        chk({name, "_valid_pulse"}, 32'(valid), 32'd0);
        chk({name, "_lo_hold"}, lo, elo);
        chk({name, "_hi_hold"}, hi, ehi);
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] q, r, ra, rb;
        logic        rs;
        int          pulses, bad;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[5] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};

        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk); resetn = 1'b1;

        for (int i = 0; i < 7; i++)
            run_div($sformatf("vec%0d", i), vecs[i].sd, vecs[i].av, vecs[i].bv,
                    vecs[i].exp_lo, vecs[i].exp_hi);

        // Cancel in the 10th BUSY cycle, then a fresh divide.
        @(negedge clk); start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        chk("cancel_stall", 32'(stall), 32'd0);
        chk("cancel_valid", 32'(valid), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        chk("cancel_no_valid", 32'(pulses), 32'd0);
        run_div("after_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // cancel wins over start while idle.
        @(negedge clk); start = 1'b1; cancel = 1'b1; a = 32'd50; b = 32'd5;
        #1;
        chk("idle_cancel_stall", 32'(stall), 32'd0);
        @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
        bad = 0;
        repeat (40) begin
            if (stall || valid) bad++;
            @(posedge clk); #1;
        end
        chk("idle_cancel_ignored", 32'(bad), 32'd0);

        // Asynchronous reset between edges mid-BUSY.
        @(negedge clk); start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3; resetn = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        @(negedge clk); resetn = 1'b1;
        run_div("post_rst", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1);
        bad = 0;
        repeat (5) begin
            if (stall || valid) bad++;
            @(posedge clk); #1;
        end
        chk("no_retrigger", 32'(bad), 32'd0);

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? ($urandom & 32'hFF) : $urandom);
            if (i == 7) begin rs = 1'b1; ra = 32'h8000_0000; end
            model(rs, ra, rb, q, r);
            run_div($sformatf("rnd%0d", i), rs, ra, rb, q, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
